// File: rtl/sc_spi_pkg.sv
// sc_spi_pkg: items shared by the SPI target engine and its master counterpart.
//   WORD_W  - width of one RX/TX data word
//   state_t - target frame state machine encoding
//   bpos()  - maps the in-word bit counter to a bit position for the selected byte order
package sc_spi_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    // border=0: whole word MSB first; border=1: byte 0 first, each byte MSB first
    function automatic logic [4:0] bpos(input logic border, input logic [4:0] n);
        logic [4:0] w_pos;
        if (border) begin
            w_pos = {n[4:3], 3'b000} + 5'd7 - {2'b00, n[2:0]};
        end else begin
            w_pos = 5'd31 - n;
        end
        return w_pos;
    endfunction

endpackage

// File: rtl/sc_spi_tgt_sync.sv
// sc_spi_tgt_sync: pin synchronizer and edge detector for the SPI target.
//   i_clk, i_rst              - system clock, synchronous active-high reset
//   i_csb, i_sclk, i_mosi     - asynchronous SPI pins
//   o_csb, o_mosi             - synchronized CSB / MOSI levels
//   o_sclk_rise, o_sclk_fall  - one-cycle strobes on synced SCLK edges
//   o_csb_rise, o_csb_fall    - one-cycle strobes on synced CSB edges
// CSB resets to the asserted (low) level so a frame already in progress when
// reset releases never produces a fall strobe; the target parks in WAIT instead.
module sc_spi_tgt_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_csb,
    input  logic i_sclk,
    input  logic i_mosi,
    output logic o_csb,
    output logic o_mosi,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_csb_rise,
    output logic o_csb_fall
);

    logic [SYNC_STAGES-1:0] r_csb_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_csb_d;
    logic                   r_sclk_d;

    // synchronizer chains plus one delayed copy for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_csb_sync  <= '0;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_csb_d     <= 1'b0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_csb_sync  <= {r_csb_sync[SYNC_STAGES-2:0], i_csb};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_csb_d     <= r_csb_sync[SYNC_STAGES-1];
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    assign o_csb       = r_csb_sync[SYNC_STAGES-1];
    assign o_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign o_sclk_rise =  r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_d;
    assign o_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] &  r_sclk_d;
    assign o_csb_rise  =  r_csb_sync[SYNC_STAGES-1]  & ~r_csb_d;
    assign o_csb_fall  = ~r_csb_sync[SYNC_STAGES-1]  &  r_csb_d;

endmodule

// File: rtl/sc_spi_tgt.sv
// sc_spi_tgt: SPI target protocol engine, oversampling the SPI pins with SPICLK.
//   SPICLK/SYSRST          - system clock (>= 8x SCLK), synchronous active-high reset
//   ENABLE/CPOL/CPHA/BORDER- mode controls, captured when a frame starts
//   TXDATA/TXDPT/TXLD      - TX word fetch interface (pointer, capture pulse)
//   RXDATA/RXVALID/RXBITS/RXDPT - received word, strobe, bit count, word index
//   FRMBUSY/FRMEND         - frame active level, end-of-frame pulse
//   CSB/SCLK/MOSI/MISO/MISOEN - SPI pins and MISO pad enable
module sc_spi_tgt
    import sc_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        SPICLK,
    input  logic        SYSRST,
    input  logic        ENABLE,
    input  logic        CPOL,
    input  logic        CPHA,
    input  logic        BORDER,
    input  logic [31:0] TXDATA,
    output logic [3:0]  TXDPT,
    output logic        TXLD,
    output logic [31:0] RXDATA,
    output logic        RXVALID,
    output logic [5:0]  RXBITS,
    output logic [3:0]  RXDPT,
    output logic        FRMBUSY,
    output logic        FRMEND,
    input  logic        CSB,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISOEN
);

    logic w_csb_s, w_mosi_s;
    logic w_sclk_rise, w_sclk_fall, w_csb_rise, w_csb_fall;
    logic w_sample, w_shift;
    logic [4:0] w_pos;
    logic [WORD_W-1:0] w_rx_word;
    state_t r_state, w_state_nxt;

    logic [WORD_W-1:0] r_txbuf, r_rxsh, r_rxdata;
    logic [4:0] r_n;
    logic [3:0] r_widx, r_txdpt, r_rxdpt;
    logic [5:0] r_rxbits;
    logic r_cpol, r_cpha, r_border;
    logic r_miso, r_miso_pend, r_misoen, r_frmbusy;
    logic r_rxvalid, r_frmend, r_txld, r_ld1, r_ld2;

    sc_spi_tgt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk       (SPICLK),
        .i_rst       (SYSRST),
        .i_csb       (CSB),
        .i_sclk      (SCLK),
        .i_mosi      (MOSI),
        .o_csb       (w_csb_s),
        .o_mosi      (w_mosi_s),
        .o_sclk_rise (w_sclk_rise),
        .o_sclk_fall (w_sclk_fall),
        .o_csb_rise  (w_csb_rise),
        .o_csb_fall  (w_csb_fall)
    );

    // modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge
    assign w_sample = (r_cpol ^ r_cpha) ? w_sclk_fall : w_sclk_rise;
    assign w_shift  = (r_cpol ^ r_cpha) ? w_sclk_rise : w_sclk_fall;

    // current RX word with the bit arriving now merged in
    always_comb begin
        w_pos            = bpos(r_border, r_n);
        w_rx_word        = r_rxsh;
        w_rx_word[w_pos] = w_mosi_s;
    end

    // frame state register
    always_ff @(posedge SPICLK) begin
        if (SYSRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state logic; CSB found low in IDLE without a fall means a frame is
    // already running, so it is skipped via WAIT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_csb_fall) begin
                    w_state_nxt = ENABLE ? ST_ACTIVE : ST_WAIT;
                end else if (!w_csb_s) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (w_csb_rise) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_WAIT: begin
                if (w_csb_s) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // shift datapath, pointers and registered outputs
    always_ff @(posedge SPICLK) begin
        if (SYSRST) begin
            r_txbuf     <= '0;
            r_rxsh      <= '0;
            r_rxdata    <= '0;
            r_n         <= 5'd0;
            r_widx      <= 4'd0;
            r_txdpt     <= 4'd0;
            r_rxdpt     <= 4'd0;
            r_rxbits    <= 6'd0;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_border    <= 1'b0;
            r_miso      <= 1'b0;
            r_miso_pend <= 1'b0;
            r_misoen    <= 1'b0;
            r_frmbusy   <= 1'b0;
            r_rxvalid   <= 1'b0;
            r_frmend    <= 1'b0;
            r_txld      <= 1'b0;
            r_ld1       <= 1'b0;
            r_ld2       <= 1'b0;
        end else begin
            r_rxvalid   <= 1'b0;
            r_frmend    <= 1'b0;
            r_txld      <= 1'b0;
            r_ld1       <= 1'b0;
            r_ld2       <= r_ld1;
            r_miso_pend <= 1'b0;
            r_misoen    <= (w_state_nxt == ST_ACTIVE);
            r_frmbusy   <= (w_state_nxt == ST_ACTIVE);
            case (r_state)
                ST_IDLE: begin
                    r_txbuf <= TXDATA;
                    r_n     <= 5'd0;
                    r_rxsh  <= '0;
                    r_miso  <= 1'b0;
                    if (w_csb_fall && ENABLE) begin
                        r_cpol      <= CPOL;
                        r_cpha      <= CPHA;
                        r_border    <= BORDER;
                        r_widx      <= 4'd0;
                        r_txdpt     <= 4'd0;
                        r_miso_pend <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    // TX word reload trails the pointer bump by two cycles so
                    // TXDATA has settled for the new TXDPT
                    if (r_ld2) begin
                        r_txbuf <= TXDATA;
                        r_txld  <= 1'b1;
                    end
                    if (r_miso_pend) begin
                        r_miso <= r_txbuf[bpos(r_border, r_n)];
                    end
                    // CSB rise has priority over a coincident sample edge
                    if (w_csb_rise) begin
                        r_frmend <= 1'b1;
                        r_txdpt  <= 4'd0;
                        r_miso   <= 1'b0;
                        if (r_n != 5'd0) begin
                            r_rxvalid <= 1'b1;
                            r_rxdata  <= r_rxsh;
                            r_rxbits  <= {1'b0, r_n};
                            r_rxdpt   <= r_widx;
                        end
                    end else if (w_sample) begin
                        r_n <= r_n + 5'd1;
                        if (r_n == 5'd31) begin
                            r_rxvalid <= 1'b1;
                            r_rxdata  <= w_rx_word;
                            r_rxbits  <= 6'd32;
                            r_rxdpt   <= r_widx;
                            r_widx    <= r_widx + 4'd1;
                            r_txdpt   <= r_txdpt + 4'd1;
                            r_rxsh    <= '0;
                            r_ld1     <= 1'b1;
                        end else begin
                            r_rxsh <= w_rx_word;
                        end
                    end else if (w_shift) begin
                        r_miso_pend <= 1'b1;
                    end else begin
                        r_n <= r_n;
                    end
                end
                ST_WAIT: begin
                    r_miso <= 1'b0;
                end
                default: begin
                    r_miso <= 1'b0;
                end
            endcase
        end
    end

    assign TXDPT   = r_txdpt;
    assign TXLD    = r_txld;
    assign RXDATA  = r_rxdata;
    assign RXVALID = r_rxvalid;
    assign RXBITS  = r_rxbits;
    assign RXDPT   = r_rxdpt;
    assign FRMBUSY = r_frmbusy;
    assign FRMEND  = r_frmend;
    assign MISO    = r_miso;
    assign MISOEN  = r_misoen;

endmodule

// File: tb/tb_sc_spi_tgt.sv
// tb_sc_spi_tgt: directed bench for sc_spi_tgt acting as an SPI master with a
// 16-entry TX word table addressed by TXDPT.
module tb_sc_spi_tgt;

    logic SPICLK = 1'b0;
    logic SYSRST = 1'b1;
    logic ENABLE = 1'b1;
    logic CPOL = 1'b0;
    logic CPHA = 1'b0;
    logic BORDER = 1'b0;
    logic CSB = 1'b1;
    logic SCLK = 1'b0;
    logic MOSI = 1'b0;
    logic [31:0] TXDATA;
    logic [3:0]  TXDPT;
    logic        TXLD;
    logic [31:0] RXDATA;
    logic        RXVALID;
    logic [5:0]  RXBITS;
    logic [3:0]  RXDPT;
    logic        FRMBUSY;
    logic        FRMEND;
    logic        MISO;
    logic        MISOEN;

    logic [31:0] tx_words [16];
    logic [63:0] mosi_stream;
    logic [63:0] miso_stream;
    logic        m_cpha;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rx_cnt = 0;
    int fe_cnt = 0;
    int txld_cnt = 0;
    int rx_cyc = 0;
    int fe_cyc = 0;
    logic misoen_seen = 1'b0;
    logic busy_seen = 1'b0;
    logic [31:0] rx_data [8];
    logic [5:0]  rx_bits [8];
    logic [3:0]  rx_dpt  [8];

    sc_spi_tgt #(.SYNC_STAGES(2)) dut (
        .SPICLK  (SPICLK),
        .SYSRST  (SYSRST),
        .ENABLE  (ENABLE),
        .CPOL    (CPOL),
        .CPHA    (CPHA),
        .BORDER  (BORDER),
        .TXDATA  (TXDATA),
        .TXDPT   (TXDPT),
        .TXLD    (TXLD),
        .RXDATA  (RXDATA),
        .RXVALID (RXVALID),
        .RXBITS  (RXBITS),
        .RXDPT   (RXDPT),
        .FRMBUSY (FRMBUSY),
        .FRMEND  (FRMEND),
        .CSB     (CSB),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .MISOEN  (MISOEN)
    );

    always #5 SPICLK = ~SPICLK;

    always_comb TXDATA = tx_words[TXDPT];

    // event recorder, sampled away from the active edge
    always @(negedge SPICLK) begin
        cyc = cyc + 1;
        if (RXVALID) begin
            if (rx_cnt < 8) begin
                rx_data[rx_cnt] = RXDATA;
                rx_bits[rx_cnt] = RXBITS;
                rx_dpt[rx_cnt]  = RXDPT;
            end
            rx_cnt = rx_cnt + 1;
            rx_cyc = cyc;
        end
        if (FRMEND) begin
            fe_cnt = fe_cnt + 1;
            fe_cyc = cyc;
        end
        if (TXLD) txld_cnt = txld_cnt + 1;
        if (MISOEN) misoen_seen = 1'b1;
        if (FRMBUSY) busy_seen = 1'b1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge SPICLK);
    endtask

    task automatic clr_mon();
        @(posedge SPICLK);
        rx_cnt = 0; fe_cnt = 0; txld_cnt = 0;
        misoen_seen = 1'b0; busy_seen = 1'b0;
        @(negedge SPICLK);
    endtask

    task automatic frame_start(input logic cpol, input logic cpha, input logic border, input logic en);
        CPOL = cpol; CPHA = cpha; BORDER = border; ENABLE = en;
        m_cpha = cpha;
        SCLK = cpol;
        wait_clks(10);
        clr_mon();
        miso_stream = '0;
        CSB = 1'b0;
    endtask

    // stream bit i travels as mosi_stream[63-i]; MISO captured likewise
    task automatic send_bits(input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            if (!m_cpha) begin
                MOSI = mosi_stream[63-i];
                wait_clks(8);
                miso_stream[63-i] = MISO;
                SCLK = ~SCLK;
                wait_clks(8);
                SCLK = ~SCLK;
            end else begin
                wait_clks(8);
                SCLK = ~SCLK;
                MOSI = mosi_stream[63-i];
                wait_clks(8);
                miso_stream[63-i] = MISO;
                SCLK = ~SCLK;
            end
        end
    endtask

    task automatic frame_stop();
        wait_clks(8);
        CSB = 1'b1;
        wait_clks(12);
    endtask

    task automatic test_reset();
        SYSRST = 1'b1;
        wait_clks(3);
        SYSRST = 1'b0;
        wait_clks(1);
        n_cmp++;
        if ({TXDPT, TXLD, RXDATA, RXVALID, RXBITS, RXDPT, FRMBUSY, FRMEND, MISO, MISOEN} !== 53'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got txdpt=%h rxdata=%h rxbits=%0d rxdpt=%h busy=%b misoen=%b, want all 0",
                     TXDPT, RXDATA, RXBITS, RXDPT, FRMBUSY, MISOEN);
        end
        wait_clks(8);
    endtask

    task automatic test_mode0_word();
        tx_words[0] = 32'h12345678;
        mosi_stream = {32'hA5A50F0F, 32'h0};
        frame_start(1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(0, 32);
        frame_stop();
        n_cmp++;
        if (rx_cnt !== 1) begin n_bad++; $display("FAIL m0_rxcount: got %0d want 1", rx_cnt); end
        n_cmp++;
        if (rx_data[0] !== 32'hA5A50F0F) begin n_bad++; $display("FAIL m0_rxdata: got %h want a5a50f0f", rx_data[0]); end
        n_cmp++;
        if (rx_bits[0] !== 6'd32 || rx_dpt[0] !== 4'd0) begin
            n_bad++; $display("FAIL m0_bits_dpt: got %0d/%0d want 32/0", rx_bits[0], rx_dpt[0]);
        end
        n_cmp++;
        if (miso_stream[63:32] !== 32'h12345678) begin n_bad++; $display("FAIL m0_miso: got %h want 12345678", miso_stream[63:32]); end
        n_cmp++;
        if (fe_cnt !== 1) begin n_bad++; $display("FAIL m0_frmend: got %0d want 1", fe_cnt); end
        n_cmp++;
        if (busy_seen !== 1'b1 || misoen_seen !== 1'b1 || FRMBUSY !== 1'b0 || MISOEN !== 1'b0) begin
            n_bad++; $display("FAIL m0_busy_en: seen %b/%b now %b/%b want 1/1 0/0", busy_seen, misoen_seen, FRMBUSY, MISOEN);
        end
        n_cmp++;
        if (txld_cnt !== 1) begin n_bad++; $display("FAIL m0_txld: got %0d want 1", txld_cnt); end
    endtask

    task automatic test_mode3_border();
        tx_words[0] = 32'hA1B2C3D4;
        mosi_stream = {32'h78563412, 32'h0};
        frame_start(1'b1, 1'b1, 1'b1, 1'b1);
        send_bits(0, 32);
        frame_stop();
        n_cmp++;
        if (rx_cnt !== 1 || rx_data[0] !== 32'h12345678) begin
            n_bad++; $display("FAIL m3_rxdata: got cnt %0d data %h want 1 12345678", rx_cnt, rx_data[0]);
        end
        n_cmp++;
        if (miso_stream[63:32] !== 32'hD4C3B2A1) begin n_bad++; $display("FAIL m3_miso: got %h want d4c3b2a1", miso_stream[63:32]); end
    endtask

    task automatic test_back_to_back();
        tx_words[0] = 32'hCAFEF00D;
        tx_words[1] = 32'hDEADBEEF;
        mosi_stream = 64'h0123456789ABCDEF;
        frame_start(1'b0, 1'b1, 1'b0, 1'b1);
        send_bits(0, 64);
        frame_stop();
        n_cmp++;
        if (rx_cnt !== 2) begin n_bad++; $display("FAIL m1_rxcount: got %0d want 2", rx_cnt); end
        n_cmp++;
        if (rx_data[0] !== 32'h01234567 || rx_dpt[0] !== 4'd0) begin
            n_bad++; $display("FAIL m1_word0: got %h/%0d want 01234567/0", rx_data[0], rx_dpt[0]);
        end
        n_cmp++;
        if (rx_data[1] !== 32'h89ABCDEF || rx_dpt[1] !== 4'd1 || rx_bits[1] !== 6'd32) begin
            n_bad++; $display("FAIL m1_word1: got %h/%0d/%0d want 89abcdef/1/32", rx_data[1], rx_dpt[1], rx_bits[1]);
        end
        n_cmp++;
        if (miso_stream !== 64'hCAFEF00DDEADBEEF) begin n_bad++; $display("FAIL m1_miso: got %h want cafef00ddeadbeef", miso_stream); end
        n_cmp++;
        if (txld_cnt !== 2) begin n_bad++; $display("FAIL m1_txld: got %0d want 2", txld_cnt); end
        n_cmp++;
        if (TXDPT !== 4'd0 || RXDPT !== 4'd1) begin n_bad++; $display("FAIL m1_ptrs: got txdpt %0d rxdpt %0d want 0 1", TXDPT, RXDPT); end
    endtask

    task automatic test_partial();
        tx_words[0] = 32'h12345678;
        mosi_stream = {12'hABC, 52'h0};
        frame_start(1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(0, 12);
        frame_stop();
        n_cmp++;
        if (rx_cnt !== 1 || rx_data[0] !== 32'hABC00000) begin
            n_bad++; $display("FAIL m2_rxdata: got cnt %0d data %h want 1 abc00000", rx_cnt, rx_data[0]);
        end
        n_cmp++;
        if (rx_bits[0] !== 6'd12) begin n_bad++; $display("FAIL m2_rxbits: got %0d want 12", rx_bits[0]); end
        n_cmp++;
        if (fe_cnt !== 1 || fe_cyc !== rx_cyc) begin
            n_bad++; $display("FAIL m2_frmend_cycle: got cnt %0d cyc %0d want 1 at rxvalid cyc %0d", fe_cnt, fe_cyc, rx_cyc);
        end
        n_cmp++;
        if (miso_stream[63:52] !== 12'h123) begin n_bad++; $display("FAIL m2_miso: got %h want 123", miso_stream[63:52]); end
    endtask

    task automatic test_disabled();
        tx_words[0] = 32'hFFFFFFFF;
        mosi_stream = {32'hFFFF0000, 32'h0};
        frame_start(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(0, 32);
        frame_stop();
        n_cmp++;
        if (rx_cnt !== 0 || fe_cnt !== 0 || misoen_seen !== 1'b0) begin
            n_bad++; $display("FAIL dis_quiet: got rx %0d fe %0d misoen %b want 0 0 0", rx_cnt, fe_cnt, misoen_seen);
        end
        n_cmp++;
        if (miso_stream[63:32] !== 32'h0) begin n_bad++; $display("FAIL dis_miso: got %h want 0", miso_stream[63:32]); end
        tx_words[0] = 32'h0F1E2D3C;
        mosi_stream = {32'h5A5AC3C3, 32'h0};
        frame_start(1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(0, 32);
        frame_stop();
        n_cmp++;
        if (rx_cnt !== 1 || rx_data[0] !== 32'h5A5AC3C3 || fe_cnt !== 1) begin
            n_bad++; $display("FAIL dis_next: got rx %0d data %h fe %0d want 1 5a5ac3c3 1", rx_cnt, rx_data[0], fe_cnt);
        end
        n_cmp++;
        if (miso_stream[63:32] !== 32'h0F1E2D3C) begin n_bad++; $display("FAIL dis_next_miso: got %h want 0f1e2d3c", miso_stream[63:32]); end
    endtask

    task automatic test_midframe_reset();
        tx_words[0] = 32'h87654321;
        mosi_stream = {32'hC0FFEE11, 32'h0};
        frame_start(1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(0, 10);
        SYSRST = 1'b1;
        wait_clks(2);
        SYSRST = 1'b0;
        wait_clks(1);
        n_cmp++;
        if ({TXDPT, TXLD, RXDATA, RXVALID, RXBITS, RXDPT, FRMBUSY, FRMEND, MISO, MISOEN} !== 53'd0) begin
            n_bad++; $display("FAIL rst_mid_outputs: got rxdata=%h busy=%b misoen=%b miso=%b want 0", RXDATA, FRMBUSY, MISOEN, MISO);
        end
        clr_mon();
        send_bits(10, 22);
        frame_stop();
        n_cmp++;
        if (rx_cnt !== 0 || fe_cnt !== 0 || misoen_seen !== 1'b0 || busy_seen !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_quiet: got rx %0d fe %0d misoen %b busy %b want 0 0 0 0", rx_cnt, fe_cnt, misoen_seen, busy_seen);
        end
        mosi_stream = {32'h3C3CA5A5, 32'h0};
        frame_start(1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(0, 32);
        frame_stop();
        n_cmp++;
        if (rx_cnt !== 1 || rx_data[0] !== 32'h3C3CA5A5 || rx_dpt[0] !== 4'd0) begin
            n_bad++; $display("FAIL rst_mid_next: got rx %0d data %h dpt %0d want 1 3c3ca5a5 0", rx_cnt, rx_data[0], rx_dpt[0]);
        end
        n_cmp++;
        if (miso_stream[63:32] !== 32'h87654321) begin n_bad++; $display("FAIL rst_mid_miso: got %h want 87654321", miso_stream[63:32]); end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) tx_words[k] = 32'h0;
        mosi_stream = '0;
        miso_stream = '0;
        m_cpha = 1'b0;
        test_reset();
        test_mode0_word();
        test_mode3_border();
        test_back_to_back();
        test_partial();
        test_disabled();
        test_midframe_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
